// File: rtl/apb_master_param_if.sv
// APB4 bus bundle between the bridge master and its peripheral slots.
interface apb_master_param_if #(
   parameter int unsigned NUM_SLAVES = 8,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32
);
   logic [ADDR_W-1:0]            PADDR;
   logic [DATA_W-1:0]            PWDATA;
   logic [DATA_W/8-1:0]          PSTRB;
   logic                         PWRITE;
   logic                         PENABLE;
   logic [NUM_SLAVES-1:0]        PSEL;
   logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
   logic [NUM_SLAVES-1:0]        PREADY;
   logic [NUM_SLAVES-1:0]        PSLVERR;

   modport master (
      output PADDR, PWDATA, PSTRB, PWRITE, PENABLE, PSEL,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PSTRB, PWRITE, PENABLE, PSEL,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_master_param.sv
// Parametrised APB4 bridge master: single-request internal bus to NUM_SLAVES
// APB slots, with decode-miss and wait-state timeout reporting.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer in flight, PSEL/PENABLE low
// SETUP  | PSEL[idx] high, PENABLE low, one cycle
// ACCESS | PSEL[idx] and PENABLE high until PREADY[idx] or timeout
// DERR   | decode miss, completes with err=10 and no bus activity
module apb_master_param #(
   parameter int unsigned       NUM_SLAVES = 8,
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h1000_0000,
   parameter int unsigned       SLOT_BITS  = 12,
   parameter int unsigned       TIMEOUT    = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   apb_master_param_if.master    apb,
   input  logic                  transfer,
   input  logic                  write,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   strb,
   output logic                  ready,
   output logic [DATA_W-1:0]     rdata,
   output logic [1:0]            err,
   output logic                  busy
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DERR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   strb_q, strb_d;
   logic                write_q, write_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

   logic [ADDR_W-1:0]   offset;
   logic [ADDR_W-1:0]   slot_num;
   logic                hit;
   logic                accept;
   logic                pready_sel;
   logic                pslverr_sel;
   logic [DATA_W-1:0]   prdata_sel;
   logic                timeout_hit;

   // Address decode of the incoming request; offset underflow is caught by the >= test.
   always_comb begin
      offset   = addr - BASE_ADDR;
      slot_num = offset >> SLOT_BITS;
      hit      = (addr >= BASE_ADDR) && (slot_num < ADDR_W'(NUM_SLAVES));
   end

   assign pready_sel  = apb.PREADY[idx_q];
   assign pslverr_sel = apb.PSLVERR[idx_q];
   assign prdata_sel  = apb.PRDATA[idx_q*DATA_W +: DATA_W];
   assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == WCNT_W'(TIMEOUT));
   assign busy        = (state_q != S_IDLE);

   // Next-state, request latching and completion outputs.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      write_d = write_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      accept  = 1'b0;
      ready   = 1'b0;
      rdata   = '0;
      err     = 2'b00;
      case (state_q)
         S_IDLE: accept = transfer;
         S_SETUP: begin
            state_d = S_ACCESS;
            wcnt_d  = WCNT_W'(1);
         end
         S_ACCESS: begin
            if (pready_sel) begin
               ready   = 1'b1;
               rdata   = prdata_sel;
               err     = {1'b0, pslverr_sel};
               accept  = transfer;
               state_d = S_IDLE;
            end else if (timeout_hit) begin
               ready   = 1'b1;
               err     = 2'b11;
               state_d = S_IDLE;
            end else if (TIMEOUT != 0) begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         S_DERR: begin
            ready   = 1'b1;
            err     = 2'b10;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A read never drives byte strobes, so its strb is latched as zero.
      if (accept) begin
         addr_d  = addr;
         wdata_d = wdata;
         write_d = write;
         strb_d  = write ? strb : '0;
         idx_d   = slot_num[IDX_W-1:0];
         state_d = hit ? S_SETUP : S_DERR;
      end
   end

   // APB outputs decoded from registered state only, so they never follow PREADY.
   always_comb begin
      apb.PSEL    = '0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      apb.PSTRB   = '0;
      apb.PADDR   = addr_q;
      apb.PWDATA  = wdata_q;
      if ((state_q == S_SETUP) || (state_q == S_ACCESS)) begin
         for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            apb.PSEL[i] = (idx_q == IDX_W'(i));
         end
         apb.PENABLE = (state_q == S_ACCESS);
         apb.PWRITE  = write_q;
         apb.PSTRB   = strb_q;
      end
   end

   // State and request registers with synchronous active-low reset.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         write_q <= 1'b0;
         idx_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
      end
   end
endmodule

// File: tb/tb_apb_master_param.sv
// Bench for apb_master_param: directed scenarios plus a randomized run checked
// against a per-transaction latency/status model.
module tb_apb_master_param;
   localparam int NS = 8;
   localparam int TO = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;

   typedef struct {
      bit          hit;
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          slot;
      int          w;
      bit          se;
      logic [31:0] rv;
   } req_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        transfer = 1'b0;
   logic        write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  strb = '0;
   logic        ready;
   logic [31:0] rdata;
   logic [1:0]  err;
   logic        busy;

   int total = 0;
   int bad = 0;

   int          wait_cfg [NS];
   logic        err_cfg  [NS];
   logic [31:0] rd_val   [NS];
   int          acc_cnt = 0;

   apb_master_param_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();

   apb_master_param #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE),
                      .SLOT_BITS(12), .TIMEOUT(TO)) dut (
      .PCLK(clk), .PRESETn(rst_n), .apb(bus.master),
      .transfer(transfer), .write(write), .addr(addr), .wdata(wdata), .strb(strb),
      .ready(ready), .rdata(rdata), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Slave model: selected slot answers after wait_cfg ACCESS cycles of PREADY low.
   always @(posedge clk) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;

   for (genvar g = 0; g < NS; g++) begin : g_slv
      assign bus.PREADY[g]          = (acc_cnt >= wait_cfg[g]);
      assign bus.PSLVERR[g]         = err_cfg[g];
      assign bus.PRDATA[g*32 +: 32] = rd_val[g];
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input req_t r);
      transfer = 1'b1;
      write    = r.wr;
      addr     = r.a;
      wdata    = r.d;
      strb     = r.s;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_3000; wdata = $urandom; strb = 4'hF;
      next_cycle; next_cycle;
      #1;
      total++; if (bus.PADDR !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", bus.PADDR); end
      total++; if (bus.PWDATA !== 32'h0) begin bad++; $display("FAIL rst_pwdata got=%h exp=0", bus.PWDATA); end
      total++; if (bus.PSTRB !== 4'h0) begin bad++; $display("FAIL rst_pstrb got=%h exp=0", bus.PSTRB); end
      total++; if (bus.PWRITE !== 1'b0) begin bad++; $display("FAIL rst_pwrite got=%b exp=0", bus.PWRITE); end
      total++; if (bus.PENABLE !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", bus.PENABLE); end
      total++; if (bus.PSEL !== 8'h00) begin bad++; $display("FAIL rst_psel got=%h exp=0", bus.PSEL); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
      total++; if (err !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      transfer = 1'b0;
      next_cycle;
      rst_n = 1'b1;
      next_cycle;
   endtask

   task automatic test_write_zero_wait();
      wait_cfg[2] = 0; err_cfg[2] = 1'b0;
      next_cycle;
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_2004; wdata = 32'hDEAD_BEEF; strb = 4'hF;
      #1;
      total++; if (ready !== 1'b0 || bus.PSEL !== 8'h00) begin bad++; $display("FAIL wr_n got ready=%b psel=%h exp 0/00", ready, bus.PSEL); end
      next_cycle; transfer = 1'b0; #1;
      total++; if (bus.PSEL !== 8'h04) begin bad++; $display("FAIL wr_setup_psel got=%h exp=04", bus.PSEL); end
      total++; if (bus.PENABLE !== 1'b0) begin bad++; $display("FAIL wr_setup_penable got=%b exp=0", bus.PENABLE); end
      total++; if (bus.PADDR !== 32'h1000_2004 || bus.PWRITE !== 1'b1 || bus.PSTRB !== 4'hF) begin bad++; $display("FAIL wr_setup_ctl got addr=%h wr=%b strb=%h", bus.PADDR, bus.PWRITE, bus.PSTRB); end
      total++; if (bus.PWDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_setup_pwdata got=%h exp=deadbeef", bus.PWDATA); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL wr_setup_ready got=%b exp=0", ready); end
      next_cycle; #1;
      total++; if (bus.PSEL !== 8'h04 || bus.PENABLE !== 1'b1) begin bad++; $display("FAIL wr_access_sel got psel=%h pen=%b exp 04/1", bus.PSEL, bus.PENABLE); end
      total++; if (ready !== 1'b1 || err !== 2'b00) begin bad++; $display("FAIL wr_access_done got ready=%b err=%b exp 1/00", ready, err); end
      total++; if (bus.PWDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_access_pwdata got=%h exp=deadbeef", bus.PWDATA); end
      next_cycle; #1;
      total++; if (bus.PSEL !== 8'h00 || busy !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL wr_idle got psel=%h busy=%b ready=%b", bus.PSEL, busy, ready); end
      total++; if (bus.PADDR !== 32'h1000_2004) begin bad++; $display("FAIL wr_idle_paddr_hold got=%h exp=10002004", bus.PADDR); end
   endtask

   task automatic test_read_wait();
      wait_cfg[5] = 3; err_cfg[5] = 1'b0; rd_val[5] = 32'h1234_5678;
      next_cycle;
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_5010; wdata = 32'h5555_AAAA; strb = 4'hF;
      for (int c = 1; c <= 5; c++) begin
         next_cycle; transfer = 1'b0; #1;
         total++; if (ready !== (c == 5)) begin bad++; $display("FAIL rd_ready c=%0d got=%b", c, ready); end
         total++; if (bus.PSEL !== 8'h20 || bus.PENABLE !== (c >= 2)) begin bad++; $display("FAIL rd_sel c=%0d got psel=%h pen=%b", c, bus.PSEL, bus.PENABLE); end
         total++; if (bus.PSTRB !== 4'h0 || bus.PWRITE !== 1'b0) begin bad++; $display("FAIL rd_strb c=%0d got strb=%h wr=%b exp 0/0", c, bus.PSTRB, bus.PWRITE); end
         if (c == 5) begin
            total++; if (rdata !== 32'h1234_5678 || err !== 2'b00) begin bad++; $display("FAIL rd_data got=%h err=%b exp 12345678/00", rdata, err); end
         end
      end
      next_cycle; #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_end_busy got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      wait_cfg[0] = 0; wait_cfg[7] = 0; err_cfg[0] = 1'b0; err_cfg[7] = 1'b0; rd_val[7] = 32'h7777_0007;
      next_cycle;
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_0008; wdata = 32'h0BAD_F00D; strb = 4'h3;
      next_cycle; transfer = 1'b0; #1;
      total++; if (bus.PSEL !== 8'h01) begin bad++; $display("FAIL b2b_setup1 got psel=%h exp=01", bus.PSEL); end
      next_cycle;
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_7000; #1;
      total++; if (ready !== 1'b1 || bus.PSEL !== 8'h01 || bus.PSTRB !== 4'h3) begin bad++; $display("FAIL b2b_done1 got ready=%b psel=%h strb=%h", ready, bus.PSEL, bus.PSTRB); end
      next_cycle; transfer = 1'b0; #1;
      total++; if (bus.PSEL !== 8'h80 || bus.PENABLE !== 1'b0 || bus.PWRITE !== 1'b0) begin bad++; $display("FAIL b2b_setup2 got psel=%h pen=%b wr=%b exp 80/0/0", bus.PSEL, bus.PENABLE, bus.PWRITE); end
      next_cycle; #1;
      total++; if (ready !== 1'b1 || rdata !== 32'h7777_0007) begin bad++; $display("FAIL b2b_done2 got ready=%b rdata=%h exp 1/77770007", ready, rdata); end
      next_cycle; #1;
      total++; if (busy !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL b2b_end got busy=%b ready=%b exp 0/0", busy, ready); end
   endtask

   task automatic test_decode_miss();
      logic [31:0] miss_addr [2];
      miss_addr[0] = 32'h1000_8000;
      miss_addr[1] = 32'h0FFF_FFFC;
      for (int m = 0; m < 2; m++) begin
         next_cycle;
         transfer = 1'b1; write = 1'b1; addr = miss_addr[m]; wdata = 32'h1; strb = 4'hF;
         next_cycle; transfer = 1'b0; #1;
         total++; if (ready !== 1'b1 || err !== 2'b10) begin bad++; $display("FAIL miss%0d_done got ready=%b err=%b exp 1/10", m, ready, err); end
         total++; if (bus.PSEL !== 8'h00 || bus.PENABLE !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL miss%0d_bus got psel=%h pen=%b rdata=%h", m, bus.PSEL, bus.PENABLE, rdata); end
         next_cycle; #1;
         total++; if (ready !== 1'b0 || busy !== 1'b0 || bus.PSEL !== 8'h00) begin bad++; $display("FAIL miss%0d_after got ready=%b busy=%b psel=%h", m, ready, busy, bus.PSEL); end
      end
   endtask

   task automatic test_slverr();
      wait_cfg[3] = 0; err_cfg[3] = 1'b1;
      next_cycle;
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_3100; wdata = 32'h3; strb = 4'h1;
      next_cycle; transfer = 1'b0;
      next_cycle; #1;
      total++; if (ready !== 1'b1 || err !== 2'b01) begin bad++; $display("FAIL slverr got ready=%b err=%b exp 1/01", ready, err); end
      err_cfg[3] = 1'b0;
      next_cycle;
   endtask

   task automatic test_timeout();
      wait_cfg[1] = 1000;
      next_cycle;
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000; wdata = 32'h0; strb = 4'h0;
      for (int c = 1; c <= 5; c++) begin
         next_cycle; transfer = 1'b0; #1;
         total++; if (ready !== (c == 5)) begin bad++; $display("FAIL tmo_ready c=%0d got=%b", c, ready); end
         if (c == 5) begin
            total++; if (err !== 2'b11 || rdata !== 32'h0) begin bad++; $display("FAIL tmo_status got err=%b rdata=%h exp 11/0", err, rdata); end
         end
      end
      next_cycle; #1;
      total++; if (bus.PSEL !== 8'h00 || ready !== 1'b0) begin bad++; $display("FAIL tmo_after got psel=%h ready=%b exp 00/0", bus.PSEL, ready); end
      wait_cfg[1] = 0;
   endtask

   task automatic test_reset_mid();
      wait_cfg[4] = 10;
      next_cycle;
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_4040; wdata = 32'hCAFE_0001; strb = 4'hF;
      next_cycle; transfer = 1'b0;
      next_cycle; #1;
      total++; if (bus.PENABLE !== 1'b1) begin bad++; $display("FAIL rmid_access got pen=%b exp=1", bus.PENABLE); end
      rst_n = 1'b0;
      next_cycle; #1;
      total++; if (bus.PSEL !== 8'h00 || bus.PENABLE !== 1'b0 || bus.PWRITE !== 1'b0 || bus.PSTRB !== 4'h0) begin bad++; $display("FAIL rmid_ctl got psel=%h pen=%b wr=%b strb=%h", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB); end
      total++; if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0) begin bad++; $display("FAIL rmid_data got addr=%h wdata=%h exp 0/0", bus.PADDR, bus.PWDATA); end
      total++; if (ready !== 1'b0 || err !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rmid_status got ready=%b err=%b busy=%b", ready, err, busy); end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         next_cycle; #1;
         total++; if (ready !== 1'b0) begin bad++; $display("FAIL rmid_no_pulse c=%0d got=%b exp=0", c, ready); end
      end
      wait_cfg[4] = 1; err_cfg[4] = 1'b0;
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_4044; wdata = 32'hCAFE_0002; strb = 4'h6;
      for (int c = 1; c <= 3; c++) begin
         next_cycle; transfer = 1'b0; #1;
         total++; if (ready !== (c == 3)) begin bad++; $display("FAIL rmid_new_ready c=%0d got=%b", c, ready); end
         if (c == 3) begin
            total++; if (err !== 2'b00 || bus.PWDATA !== 32'hCAFE_0002) begin bad++; $display("FAIL rmid_new_done got err=%b pwdata=%h", err, bus.PWDATA); end
         end
      end
      next_cycle;
   endtask

   task automatic test_random();
      req_t reqs [$];
      req_t r;
      bit   chained;
      bit   chained_next;
      int   lat;
      int   gap;
      logic [1:0]  exp_err;
      logic [31:0] exp_rd;
      for (int t = 0; t < 60; t++) begin
         r.hit  = ($urandom_range(0, 3) != 0);
         r.slot = $urandom_range(0, NS - 1);
         r.wr   = $urandom_range(0, 1);
         r.d    = $urandom;
         r.s    = 4'($urandom);
         r.w    = $urandom_range(0, 5);
         r.se   = ($urandom_range(0, 3) == 0);
         r.rv   = $urandom;
         if (r.hit)
            r.a = BASE + (r.slot << 12) + ($urandom & 32'hFFC);
         else if ($urandom_range(0, 1) == 1)
            r.a = BASE + ((NS + $urandom_range(0, 100)) << 12) + ($urandom & 32'hFFC);
         else
            r.a = $urandom_range(0, 32'h0FFF_FFFF);
         reqs.push_back(r);
      end
      chained = 1'b0;
      for (int t = 0; t < reqs.size(); t++) begin
         r = reqs[t];
         if (!chained) begin
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
               next_cycle; #1;
               total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_gap t=%0d got busy=%b exp=0", t, busy); end
            end
            next_cycle;
            drive_req(r);
            #1;
            total++; if (busy !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL rnd_accept t=%0d got busy=%b ready=%b", t, busy, ready); end
         end
         // Expected completion from the request alone: miss 1 cycle, timeout after TO waits.
         if (!r.hit) begin
            lat = 1; exp_err = 2'b10; exp_rd = '0;
         end else if (r.w >= TO) begin
            lat = 1 + TO; exp_err = 2'b11; exp_rd = '0;
         end else begin
            lat = 2 + r.w; exp_err = {1'b0, r.se}; exp_rd = r.rv;
         end
         chained_next = 1'b0;
         for (int c = 1; c <= lat; c++) begin
            next_cycle;
            transfer = 1'b0;
            if (c == 1 && r.hit) begin
               wait_cfg[r.slot] = r.w; err_cfg[r.slot] = r.se; rd_val[r.slot] = r.rv;
            end
            if (c == lat && r.hit && r.w < TO && t + 1 < reqs.size() && $urandom_range(0, 1) == 1) begin
               drive_req(reqs[t+1]);
               chained_next = 1'b1;
            end
            #1;
            total++; if (ready !== (c == lat)) begin bad++; $display("FAIL rnd_ready t=%0d c=%0d got=%b exp=%b", t, c, ready, (c == lat)); end
            if (r.hit) begin
               total++; if (bus.PSEL !== (8'h1 << r.slot) || bus.PENABLE !== (c >= 2)) begin bad++; $display("FAIL rnd_sel t=%0d c=%0d got psel=%h pen=%b slot=%0d", t, c, bus.PSEL, bus.PENABLE, r.slot); end
               total++; if (bus.PADDR !== r.a || bus.PWDATA !== r.d || bus.PWRITE !== r.wr || bus.PSTRB !== (r.wr ? r.s : 4'h0)) begin bad++; $display("FAIL rnd_bus t=%0d c=%0d got addr=%h wdata=%h wr=%b strb=%h exp %h/%h/%b", t, c, bus.PADDR, bus.PWDATA, bus.PWRITE, bus.PSTRB, r.a, r.d, r.wr); end
            end else begin
               total++; if (bus.PSEL !== 8'h00 || bus.PENABLE !== 1'b0) begin bad++; $display("FAIL rnd_miss_bus t=%0d got psel=%h pen=%b", t, bus.PSEL, bus.PENABLE); end
            end
            if (c == lat) begin
               total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err t=%0d got=%b exp=%b", t, err, exp_err); end
               if (!r.wr || exp_err[1]) begin
                  total++; if (rdata !== exp_rd) begin bad++; $display("FAIL rnd_rdata t=%0d got=%h exp=%h", t, rdata, exp_rd); end
               end
            end
         end
         chained = chained_next;
      end
      next_cycle; #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_end got busy=%b exp=0", busy); end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         wait_cfg[i] = 0;
         err_cfg[i]  = 1'b0;
         rd_val[i]   = 32'hA000_0000 + i;
      end
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_back_to_back();
      test_decode_miss();
      test_slverr();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
